// File: rtl/hyperbus_burst_ctrl.sv
// HyperBus burst master: drives a 48-bit CA phase, waits the initial latency and
// moves 1..MAX_BURST 16-bit words over the 8-bit DDR DQ bus with a user handshake.
module hyperbus_burst_ctrl #(
    parameter string TARGET        = "SIM",
    parameter int    LATENCY       = 6,
    parameter int    FIXED_LATENCY = 0,
    parameter int    MAX_BURST     = 32,
    parameter int    RD_TIMEOUT    = 64,
    localparam int   LEN_W         = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             hbus_clk,
    output logic             hbus_csn,
    output logic             hbus_rstn,
    inout  wire  [7:0]       hbus_dq,
    inout  wire              hbus_rwds,
    input  logic [31:0]      addr,
    input  logic [LEN_W-1:0] len,
    input  logic             wrq,
    input  logic             rrq,
    input  logic [15:0]      din,
    output logic             dready,
    output logic [15:0]      dout,
    output logic             dvalid,
    output logic             busy,
    output logic             error
);

    typedef enum logic [2:0] {ST_IDLE, ST_CA, ST_LAT, ST_WDATA, ST_RDATA, ST_END} state_t;

    localparam int               TO_W        = $clog2(RD_TIMEOUT + 1);
    localparam logic [LEN_W-1:0] MAX_LEN     = LEN_W'(MAX_BURST);
    localparam logic [7:0]       LAT_LAST_1X = 8'(2 * LATENCY - 1);
    localparam logic [7:0]       LAT_LAST_2X = 8'(4 * LATENCY - 1);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(RD_TIMEOUT - 1);

    state_t           state;
    logic [47:0]      ca_sr;
    logic [47:0]      ca_next;
    logic [7:0]       cnt;
    logic [7:0]       lat_last;
    logic [LEN_W-1:0] words;
    logic             is_rd;
    logic             lat_dbl;
    logic             in_lo;
    logic             rd_phase;
    logic             rwds_q;
    logic             rwds_chg;
    logic [7:0]       dq_out;
    logic [7:0]       wlo;
    logic [7:0]       rd_hi;
    logic             dq_oe;
    logic             rwds_oe;
    logic [TO_W-1:0]  to_cnt;

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
        if (l == '0) return LEN_W'(1);
        if (l > MAX_LEN) return MAX_LEN;
        return l;
    endfunction

    function automatic logic [47:0] ca_word(input logic rd, input logic [31:0] a);
        return {rd, 1'b0, 1'b1, a[31:3], 13'd0, a[2:0]};
    endfunction

    assign ca_next  = ca_word(rrq, addr);
    assign lat_last = lat_dbl ? LAT_LAST_2X : LAT_LAST_1X;
    assign rwds_chg = (hbus_rwds != rwds_q);

    generate
        if (TARGET == "SIM") begin : g_pads_sim
            assign hbus_dq   = dq_oe   ? dq_out : 8'bz;
            assign hbus_rwds = rwds_oe ? 1'b0   : 1'bz;
        end else begin : g_pads_vendor
            // Vendor IO buffers are not wired up yet; the behavioural pads keep the block usable.
            assign hbus_dq   = dq_oe   ? dq_out : 8'bz;
            assign hbus_rwds = rwds_oe ? 1'b0   : 1'bz;
        end
    endgenerate

    always_ff @(posedge clk) begin
        hbus_rstn <= ~rst;
        rwds_q    <= hbus_rwds;
        if (rst) begin
            state    <= ST_IDLE;
            hbus_csn <= 1'b1;
            hbus_clk <= 1'b0;
            dq_oe    <= 1'b0;
            rwds_oe  <= 1'b0;
            dready   <= 1'b0;
            dvalid   <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b0;
            dout     <= 16'd0;
            cnt      <= 8'd0;
            words    <= '0;
            is_rd    <= 1'b0;
            lat_dbl  <= 1'b0;
            in_lo    <= 1'b0;
            rd_phase <= 1'b0;
            to_cnt   <= '0;
        end else begin
            dready <= 1'b0;
            dvalid <= 1'b0;
            error  <= 1'b0;
            if (!hbus_csn) hbus_clk <= ~hbus_clk;

            case (state)
                ST_IDLE: begin
                    // Read wins when both requests arrive together.
                    if (rrq || wrq) begin
                        state    <= ST_CA;
                        busy     <= 1'b1;
                        hbus_csn <= 1'b0;
                        hbus_clk <= 1'b0;
                        is_rd    <= rrq;
                        words    <= sat_len(len);
                        ca_sr    <= ca_next;
                        dq_out   <= ca_next[47:40];
                        dq_oe    <= 1'b1;
                        cnt      <= 8'd0;
                    end
                end

                ST_CA: begin
                    dq_out <= ca_sr[39:32];
                    ca_sr  <= ca_sr << 8;
                    cnt    <= cnt + 8'd1;
                    if (cnt == 8'd2) lat_dbl <= (FIXED_LATENCY != 0) || hbus_rwds;
                    if (cnt == 8'd5) begin
                        dq_oe    <= 1'b0;
                        cnt      <= 8'd0;
                        to_cnt   <= '0;
                        rd_phase <= 1'b0;
                        state    <= is_rd ? ST_RDATA : ST_LAT;
                    end
                end

                ST_LAT: begin
                    cnt <= cnt + 8'd1;
                    // Fetch the first word one cycle early so its high byte leads the data phase.
                    if (cnt == lat_last - 8'd1) dready <= 1'b1;
                    if (cnt == lat_last) begin
                        state   <= ST_WDATA;
                        dq_out  <= din[15:8];
                        wlo     <= din[7:0];
                        dq_oe   <= 1'b1;
                        rwds_oe <= 1'b1;
                        in_lo   <= 1'b0;
                    end
                end

                ST_WDATA: begin
                    if (!in_lo) begin
                        dq_out <= wlo;
                        in_lo  <= 1'b1;
                        if (words != LEN_W'(1)) dready <= 1'b1;
                    end else if (words == LEN_W'(1)) begin
                        state    <= ST_END;
                        hbus_csn <= 1'b1;
                        hbus_clk <= 1'b0;
                        dq_oe    <= 1'b0;
                        rwds_oe  <= 1'b0;
                        cnt      <= 8'd0;
                    end else begin
                        dq_out <= din[15:8];
                        wlo    <= din[7:0];
                        words  <= words - LEN_W'(1);
                        in_lo  <= 1'b0;
                    end
                end

                ST_RDATA: begin
                    if (rwds_chg) begin
                        to_cnt <= '0;
                        if (!rd_phase) begin
                            rd_hi    <= hbus_dq;
                            rd_phase <= 1'b1;
                        end else begin
                            dout     <= {rd_hi, hbus_dq};
                            dvalid   <= 1'b1;
                            rd_phase <= 1'b0;
                            words    <= words - LEN_W'(1);
                            if (words == LEN_W'(1)) begin
                                state    <= ST_END;
                                hbus_csn <= 1'b1;
                                hbus_clk <= 1'b0;
                                cnt      <= 8'd0;
                            end
                        end
                    end else if (to_cnt == TO_LAST) begin
                        error    <= 1'b1;
                        state    <= ST_END;
                        hbus_csn <= 1'b1;
                        hbus_clk <= 1'b0;
                        cnt      <= 8'd0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                ST_END: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'd1) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
